// File: rtl/gate_bist.sv
// Built-in self test for a six-gate block: drives the four {a,b} vectors, compares the gate outputs, and reports a pass flag and per-gate fail mask.
// Optional first-failure capture (fail_valid/fail_vec) is enabled by defining GATE_BIST_FAIL_CAPTURE_EN.
module gate_bist #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       drv_a,
  output logic       drv_b,
  input  logic [5:0] obs,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] fail_mask
`ifdef GATE_BIST_FAIL_CAPTURE_EN
  ,
  output logic       fail_valid,
  output logic [1:0] fail_vec
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_SAMPLE, ST_DONE} state_t;

  localparam logic [3:0] LP_LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic       r_drv_a;
  logic       r_drv_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [5:0] r_fail_mask;

  logic [5:0] w_expect;
  logic [5:0] w_mismatch;
  logic [5:0] w_mask_next;
  logic [1:0] w_idx_next;

  // Expected response is formed from the registered stimulus, so it matches what the gates see.
  assign w_expect    = {~r_drv_a, ~(r_drv_a | r_drv_b), ~(r_drv_a & r_drv_b),
                        r_drv_a ^ r_drv_b, r_drv_a | r_drv_b, r_drv_a & r_drv_b};
  assign w_mismatch  = obs ^ w_expect;
  assign w_mask_next = r_fail_mask | w_mismatch;
  assign w_idx_next  = r_idx + 2'd1;

`ifdef GATE_BIST_FAIL_CAPTURE_EN
  logic       r_fail_valid;
  logic [1:0] r_fail_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_valid <= 1'b0;
      r_fail_vec   <= 2'd0;
    end else if (r_state == ST_IDLE && start) begin
      r_fail_valid <= 1'b0;
      r_fail_vec   <= 2'd0;
    end else if (r_state == ST_SAMPLE && (|w_mismatch) && !r_fail_valid) begin
      r_fail_valid <= 1'b1;
      r_fail_vec   <= r_idx;
    end
  end

  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= 4'd0;
      r_drv_a     <= 1'b0;
      r_drv_b     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_mask <= 6'd0;
    end else begin
      // NOTE: default here makes done a single-cycle pulse without extra state.
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_fail_mask <= 6'd0;
            r_pass      <= 1'b0;
            r_idx       <= 2'd0;
            r_cnt       <= 4'd0;
            r_drv_a     <= 1'b0;
            r_drv_b     <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == LP_LAST_SETTLE) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_SAMPLE: begin
          r_fail_mask <= w_mask_next;
          if (r_idx == 2'd3) begin
            r_done  <= 1'b1;
            r_pass  <= (w_mask_next == 6'd0);
            r_busy  <= 1'b0;
            r_drv_a <= 1'b0;
            r_drv_b <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_idx   <= w_idx_next;
            r_cnt   <= 4'd0;
            r_drv_a <= w_idx_next[1];
            r_drv_b <= w_idx_next[0];
            r_state <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign drv_a     = r_drv_a;
  assign drv_b     = r_drv_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_mask = r_fail_mask;

endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench for gate_bist: emulates a six-gate block with injectable stuck-at faults and checks timing and results against a cycle/arithmetic model.
module tb_gate_bist;

  localparam int SC       = 2;
  localparam int RUN_LEN  = 4 * (SC + 1) + 1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       drv_a;
  logic       drv_b;
  logic [5:0] obs;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] fail_mask;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
  logic       fail_valid;
  logic [1:0] fail_vec;
`endif

  logic [5:0] sa0;
  logic [5:0] sa1;
  int         total;
  int         bad;

  gate_bist #(.SETTLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .drv_a     (drv_a),
    .drv_b     (drv_b),
    .obs       (obs),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask)
`ifdef GATE_BIST_FAIL_CAPTURE_EN
    ,
    .fail_valid(fail_valid),
    .fail_vec  (fail_vec)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Healthy gate outputs computed arithmetically from the input values.
  function automatic logic [5:0] gate_model(input int a, input int b);
    logic [5:0] m;
    int and_v;
    int or_v;
    and_v = a * b;
    or_v  = (a + b > 0) ? 1 : 0;
    m[0]  = 1'(and_v);
    m[1]  = 1'(or_v);
    m[2]  = 1'((a + b) % 2);
    m[3]  = 1'(1 - and_v);
    m[4]  = 1'(1 - or_v);
    m[5]  = 1'(1 - a);
    return m;
  endfunction

  function automatic logic [5:0] faulty(input int a, input int b);
    return (gate_model(a, b) & ~sa0) | sa1;
  endfunction

  always_comb obs = faulty(int'(drv_a), int'(drv_b));

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One complete run from the start pulse; glitch re-pulses start in cycle 5 and in the DONE cycle.
  task automatic run_and_check(input bit glitch);
    logic [5:0] exp_mask;
    int         first_fail;
    int         idx;
    exp_mask   = 6'd0;
    first_fail = -1;
    for (int v = 0; v < 4; v++) begin
      logic [5:0] mm;
      mm = faulty(v / 2, v % 2) ^ gate_model(v / 2, v % 2);
      exp_mask |= mm;
      if (mm != 6'd0 && first_fail < 0) first_fail = v;
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= RUN_LEN; c++) begin
      if (c == 1) begin
        check("pass_cleared", 8'(pass), 8'd0);
        check("mask_cleared", 8'(fail_mask), 8'd0);
      end
      if (c < RUN_LEN) begin
        idx = (c - 1) / (SC + 1);
        check($sformatf("busy_c%0d", c), 8'(busy), 8'd1);
        check($sformatf("drv_c%0d", c), 8'({drv_a, drv_b}), 8'(idx));
        check($sformatf("done_c%0d", c), 8'(done), 8'd0);
      end else begin
        check("done_pulse", 8'(done), 8'd1);
        check("busy_done", 8'(busy), 8'd0);
        check("drv_done", 8'({drv_a, drv_b}), 8'd0);
        check("pass", 8'(pass), 8'(exp_mask == 6'd0));
        check("fail_mask", 8'(fail_mask), 8'(exp_mask));
`ifdef GATE_BIST_FAIL_CAPTURE_EN
        check("fail_valid", 8'(fail_valid), 8'(first_fail >= 0));
        if (first_fail >= 0) check("fail_vec", 8'(fail_vec), 8'(first_fail));
`endif
      end
      start = glitch && (c == 5 || c == RUN_LEN);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_single", 8'(done), 8'd0);
    check("busy_after", 8'(busy), 8'd0);
    check("pass_held", 8'(pass), 8'(exp_mask == 6'd0));
    check("mask_held", 8'(fail_mask), 8'(exp_mask));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    sa0   = 6'd0;
    sa1   = 6'd0;

    #1;
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_pass", 8'(pass), 8'd0);
    check("rst_mask", 8'(fail_mask), 8'd0);
    check("rst_drv", 8'({drv_a, drv_b}), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Healthy gates with ignored start pulses, then an immediate back-to-back run.
    run_and_check(1'b1);
    run_and_check(1'b0);

    // AND stuck at 0.
    sa0 = 6'b000001;
    run_and_check(1'b0);

    // All outputs tied low.
    sa0 = 6'b111111;
    run_and_check(1'b0);

    // Random stuck-at faults.
    for (int k = 0; k < 6; k++) begin
      sa0 = 6'($urandom_range(0, 63) & $urandom_range(0, 63));
      sa1 = 6'($urandom_range(0, 63) & $urandom_range(0, 63) & $urandom_range(0, 63));
      run_and_check(1'b0);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a failing run.
    sa0 = 6'd0;
    sa1 = 6'b000001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_mask", 8'(fail_mask), 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 8'(busy), 8'd0);
    check("arst_drv", 8'({drv_a, drv_b}), 8'd0);
    check("arst_pass", 8'(pass), 8'd0);
    check("arst_mask", 8'(fail_mask), 8'd0);
    check("arst_done", 8'(done), 8'd0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      check($sformatf("no_done_%0d", c), 8'(done), 8'd0);
    end
    sa1 = 6'd0;
    run_and_check(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

endmodule
